counter_group_ctrl: RTL and testbench

COUNTER_GROUP_CTRL -- requirements
Module: counter_group_ctrl

---
 rtl/counter_group_ctrl.sv | 156 +++++++++++++++
 tb/tb_counter_group_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_group_ctrl.sv
// rtl/counter_group_ctrl.sv - button debounce/auto-repeat front end and pulse sequencer for a counter group
module counter_group_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] REPEAT_DELAY    = 24'd5000000,
  parameter logic [23:0] REPEAT_PERIOD   = 24'd1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_sel,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_clr,
  output logic selector,
  output logic incrementor,
  output logic reverse,
  output logic clr,
  output logic busy
);

  localparam logic [1:0] K_CLR = 2'd0;
  localparam logic [1:0] K_SEL = 2'd1;
  localparam logic [1:0] K_UP  = 2'd2;
  localparam logic [1:0] K_DN  = 2'd3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_PULSE = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [3:0]       raw;
  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       db_q, db_d, db_prev_q;
  logic [3:0][15:0] deb_cnt_q, deb_cnt_d;

  assign raw = {btn_down, btn_up, btn_sel, btn_clr};

  always_comb begin
    db_d      = db_q;
    deb_cnt_d = deb_cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == db_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEBOUNCE_CYCLES - 16'd1) begin
        db_d[i]      = sync2_q[i];
        deb_cnt_d[i] = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + 16'd1;
      end
    end
  end

  logic [3:0]  rise;
  logic        up_only, dn_only, up_only_q, dn_only_q, held_run;
  logic [23:0] rep_cnt_q, rep_cnt_d;
  logic        rep_phase_q, rep_phase_d, rep_ev;
  logic [3:0]  ev;

  assign rise     = db_q & ~db_prev_q;
  assign up_only  = db_q[K_UP] & ~db_q[K_DN];
  assign dn_only  = db_q[K_DN] & ~db_q[K_UP];
  // The repeat timer only runs while the same single direction stays held; any change restarts it.
  assign held_run = (up_only & up_only_q) | (dn_only & dn_only_q);

  always_comb begin
    rep_ev      = 1'b0;
    rep_cnt_d   = '0;
    rep_phase_d = 1'b0;
    if (held_run) begin
      rep_ev      = rep_phase_q ? (rep_cnt_q == REPEAT_PERIOD - 24'd1)
                                : (rep_cnt_q == REPEAT_DELAY - 24'd1);
      rep_phase_d = rep_phase_q | rep_ev;
      rep_cnt_d   = rep_ev ? '0 : rep_cnt_q + 24'd1;
    end
  end

  assign ev[K_CLR] = rise[K_CLR];
  assign ev[K_SEL] = rise[K_SEL];
  assign ev[K_UP]  = up_only & (rise[K_UP] | rep_ev);
  assign ev[K_DN]  = dn_only & (rise[K_DN] | rep_ev);

  logic [1:0] state_q, state_d, kind_q, kind_d;
  logic [3:0] pend_q, pend_d;
  logic       reverse_q, reverse_d;

  always_comb begin
    kind_d    = kind_q;
    reverse_d = reverse_q;
    pend_d    = pend_q;
    case (state_q)
      S_SETUP: state_d = S_PULSE;
      S_PULSE: state_d = S_GAP;
      default: state_d = S_IDLE;
    endcase
    // Issuing straight from GAP keeps back-to-back events at one per three cycles.
    if ((state_q == S_IDLE || state_q == S_GAP) && (|pend_q)) begin
      state_d = S_SETUP;
      if (pend_q[K_CLR]) begin
        kind_d       = K_CLR;
        pend_d[K_CLR] = 1'b0;
        pend_d[K_UP]  = 1'b0;
        pend_d[K_DN]  = 1'b0;
      end else if (pend_q[K_SEL]) begin
        kind_d        = K_SEL;
        pend_d[K_SEL] = 1'b0;
      end else if (pend_q[K_UP]) begin
        kind_d       = K_UP;
        reverse_d    = 1'b0;
        pend_d[K_UP] = 1'b0;
      end else begin
        kind_d       = K_DN;
        reverse_d    = 1'b1;
        pend_d[K_DN] = 1'b0;
      end
    end
    pend_d = pend_d | (ev & ~pend_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      db_q        <= '0;
      db_prev_q   <= '0;
      deb_cnt_q   <= '0;
      up_only_q   <= 1'b0;
      dn_only_q   <= 1'b0;
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
      state_q     <= S_IDLE;
      kind_q      <= K_CLR;
      pend_q      <= '0;
      reverse_q   <= 1'b0;
    end else begin
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      db_q        <= db_d;
      db_prev_q   <= db_q;
      deb_cnt_q   <= deb_cnt_d;
      up_only_q   <= up_only;
      dn_only_q   <= dn_only;
      rep_cnt_q   <= rep_cnt_d;
      rep_phase_q <= rep_phase_d;
      state_q     <= state_d;
      kind_q      <= kind_d;
      pend_q      <= pend_d;
      reverse_q   <= reverse_d;
    end
  end

  assign selector    = (state_q == S_PULSE) && (kind_q == K_SEL);
  assign incrementor = (state_q == S_PULSE) && (kind_q == K_UP || kind_q == K_DN);
  assign clr         = (state_q == S_PULSE) && (kind_q == K_CLR);
  assign reverse     = reverse_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_counter_group_ctrl.sv
// tb/tb_counter_group_ctrl.sv - directed and randomized checks of counter_group_ctrl against a timing model
module tb_counter_group_ctrl;
  localparam int DEB = 4;
  localparam int DLY = 20;
  localparam int PER = 8;

  logic clk = 1'b0;
  logic rst;
  logic btn_sel, btn_up, btn_down, btn_clr;
  logic selector, incrementor, reverse, clr, busy;

  always #5 clk = ~clk;

  counter_group_ctrl #(
    .DEBOUNCE_CYCLES(16'd4),
    .REPEAT_DELAY   (24'd20),
    .REPEAT_PERIOD  (24'd8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_sel    (btn_sel),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_clr    (btn_clr),
    .selector   (selector),
    .incrementor(incrementor),
    .reverse    (reverse),
    .clr        (clr),
    .busy       (busy)
  );

  int errors = 0;
  int checks = 0;
  int k = 0;

  // Reference model; index 0=CLR 1=SEL 2=UP 3=DOWN doubles as issue priority.
  bit m_s1[4], m_s2[4], m_db[4], m_dbo[4];
  int m_run[4];
  int m_mode, m_run_start;
  bit m_pend[4];
  int m_last_issue, m_last_kind;
  bit m_rev;

  int last_pulse = -1000;
  int n_sel, n_inc, n_clr, n_busy, n_inc_rev1, n_inc_rev0;
  int inc_t[$];
  int sel_t, clr_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_dbo[i] = 0; m_run[i] = 0; m_pend[i] = 0;
    end
    m_mode = 0;
    m_run_start = k;
    m_last_issue = -1000;
    m_last_kind = 0;
    m_rev = 0;
  endfunction

  function automatic void model_step(input logic [3:0] b, input logic r);
    bit ev[4];
    bit old_pend[4];
    int d, kk, iss, newmode;
    if (r) begin
      model_reset();
      return;
    end
    ev[0] = m_db[0] && !m_dbo[0];
    ev[1] = m_db[1] && !m_dbo[1];
    ev[2] = 0;
    ev[3] = 0;
    if (m_mode != 0) begin
      d  = (k - 1) - m_run_start;
      kk = (m_mode == 1) ? 2 : 3;
      ev[kk] = (d == 0 && !m_dbo[kk]) || d == DLY || (d > DLY && (d - DLY) % PER == 0);
    end
    iss = -1;
    if (k - 1 >= m_last_issue + 3) begin
      for (int i = 0; i < 4; i++) if (iss < 0 && m_pend[i]) iss = i;
    end
    old_pend = m_pend;
    if (iss >= 0) begin
      m_pend[iss] = 0;
      if (iss == 0) begin m_pend[2] = 0; m_pend[3] = 0; end
      m_last_issue = k - 1;
      m_last_kind = iss;
      if (iss == 2) m_rev = 0;
      if (iss == 3) m_rev = 1;
    end
    for (int i = 0; i < 4; i++) if (ev[i] && !old_pend[i]) m_pend[i] = 1;
    for (int i = 0; i < 4; i++) begin
      m_dbo[i] = m_db[i];
      if (m_s2[i] != m_db[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin m_db[i] = m_s2[i]; m_run[i] = 0; end
      end else m_run[i] = 0;
      m_s2[i] = m_s1[i];
      m_s1[i] = b[i];
    end
    newmode = (m_db[2] && !m_db[3]) ? 1 : (m_db[3] && !m_db[2]) ? 2 : 0;
    if (newmode != m_mode) begin m_mode = newmode; m_run_start = k; end
  endfunction

  task automatic cycle(input logic [3:0] b, input logic r);
    logic [4:0] exp;
    int dt;
    bit pulse;
    {btn_down, btn_up, btn_sel, btn_clr} = b;
    rst = r;
    @(posedge clk);
    k++;
    model_step(b, r);
    @(negedge clk);
    dt = k - m_last_issue;
    pulse = (dt == 2);
    exp = {pulse && m_last_kind == 1, pulse && m_last_kind >= 2, pulse && m_last_kind == 0,
           m_rev, dt >= 1 && dt <= 3};
    chk("outputs", 32'({selector, incrementor, clr, reverse, busy}), 32'(exp));
    chk("one_hot", 32'(int'(selector) + int'(incrementor) + int'(clr) <= 1), 32'd1);
    if (selector || incrementor || clr) begin
      chk("pulse_gap", 32'(k - last_pulse >= 3), 32'd1);
      last_pulse = k;
    end
    if (selector) begin n_sel++; sel_t = k; end
    if (clr) begin n_clr++; clr_t = k; end
    if (incrementor) begin
      n_inc++;
      inc_t.push_back(k);
      if (reverse) n_inc_rev1++; else n_inc_rev0++;
    end
    if (busy) n_busy++;
  endtask

  task automatic hold(input logic [3:0] b, input int n);
    for (int i = 0; i < n; i++) cycle(b, 1'b0);
  endtask

  task automatic clr_counts();
    n_sel = 0; n_inc = 0; n_clr = 0; n_busy = 0; n_inc_rev1 = 0; n_inc_rev0 = 0;
    inc_t.delete();
    sel_t = -1; clr_t = -1;
  endtask

  initial begin
    logic [3:0] rb;
    int rel_k, waited;
    model_reset();
    clr_counts();
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);
    chk("reset_outputs", 32'({selector, incrementor, clr, reverse, busy}), 32'd0);

    // Short press and bounces must be rejected, a steady 20-cycle press gives one step.
    hold(4'b0100, 3); hold(4'b0000, 3);
    for (int i = 0; i < 5; i++) begin hold(4'b0100, 1); hold(4'b0000, 1); end
    hold(4'b0000, 10);
    chk("bounce_no_pulse", 32'(n_inc + n_sel + n_clr), 32'd0);
    clr_counts();
    hold(4'b0100, 20); hold(4'b0000, 20);
    chk("up20_inc_count", 32'(n_inc), 32'd1);
    chk("up20_reverse_set", 32'(n_inc_rev1), 32'd0);
    chk("up20_busy_cycles", 32'(n_busy), 32'd3);

    // Down held 60 cycles: first step, repeat after 20, then every 8.
    clr_counts();
    hold(4'b1000, 60); hold(4'b0000, 20);
    chk("down60_inc_count", 32'(n_inc), 32'(1 + (60 - DLY) / PER));
    chk("down60_reverse_clear", 32'(n_inc_rev0), 32'd0);
    chk("down60_delay", 32'(inc_t.size() >= 3 ? inc_t[1] - inc_t[0] : -1), 32'(DLY));
    chk("down60_period", 32'(inc_t.size() >= 3 ? inc_t[2] - inc_t[1] : -1), 32'(PER));

    // CLR, SEL and UP together: CLR first, SEL three cycles later, UP dropped.
    clr_counts();
    hold(4'b0111, 10); hold(4'b0000, 30);
    chk("combo_clr_count", 32'(n_clr), 32'd1);
    chk("combo_sel_count", 32'(n_sel), 32'd1);
    chk("combo_up_dropped", 32'(n_inc), 32'd0);
    chk("combo_sel_after_clr", 32'(sel_t - clr_t), 32'd3);

    // Both directions held: silence; dropping down leaves up to repeat after the delay.
    clr_counts();
    hold(4'b1100, 100);
    chk("both_held_no_pulse", 32'(n_inc), 32'd0);
    rel_k = k;
    hold(4'b0100, 30); hold(4'b0000, 20);
    chk("released_down_count", 32'(n_inc), 32'd2);
    chk("released_down_delay", 32'(inc_t.size() > 0 && inc_t[0] - rel_k >= DLY), 32'd1);

    // Reset in the middle of a selector pulse with UP still pending.
    hold(4'b1000, 8); hold(4'b0000, 15);
    chk("reverse_before_rst", 32'(reverse), 32'd1);
    clr_counts();
    waited = 0;
    do begin cycle(4'b0110, 1'b0); waited++; end while (!selector && waited < 40);
    chk("sel_pulse_seen", 32'(selector), 32'd1);
    cycle(4'b0000, 1'b1);
    chk("rst_pulse_low", 32'({selector, incrementor, clr}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_reverse", 32'(reverse), 32'd0);
    clr_counts();
    hold(4'b0000, 40);
    chk("no_stray_after_rst", 32'(n_inc + n_sel + n_clr), 32'd0);

    // Random button activity with occasional resets.
    rb = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      for (int j = 0; j < 4; j++) if ($urandom_range(0, 11) == 0) rb[j] = ~rb[j];
      cycle(rb, ($urandom_range(0, 499) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
